// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: inverse S-box table, FSM states, datapath widths
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // FIPS-197 inverse S-box, entry x at index x.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational AES inverse S-box lookup
// Ports: in_byte (8) -> out_byte (8) = INV_SBOX[in_byte]
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// rtl/aes_inv_sub_bytes_seq.sv - iterative InvSubBytes, one 32-bit word per cycle
// Ports: clk, rst (async, active-high);
//        in_valid/in_ready/in_state[127:0]    block input handshake
//        out_valid/out_ready/out_state[127:0] result output handshake
module aes_inv_sub_bytes_seq
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    fsm_state_e         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [STATE_W-1:0] data_q, data_d;

    logic [WORD_W-1:0]  word_in;
    logic [WORD_W-1:0]  word_out;

    // Word cnt starts at bit 32*cnt, i.e. {cnt, 5'b0}.
    assign word_in = data_q[{cnt_q, 5'b0} +: WORD_W];

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .in_byte  (word_in[8*i +: 8]),
            .out_byte (word_out[8*i +: 8])
        );
    end

    assign out_state = data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_state;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                data_d[{cnt_q, 5'b0} +: WORD_W] = word_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Ready for a new block exactly when the current one drains,
                // so a block can be handed over in the same cycle.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        data_d  = in_state;
                        cnt_d   = 2'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// tb/tb_aes_inv_sub_bytes_seq.sv - self-checking bench for aes_inv_sub_bytes_seq
module tb_aes_inv_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int n_total;
    int n_pass;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    aes_inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Hands one block in, checks the 4-cycle latency and the result, then drains it.
    task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input string tag);
        int n;
        in_state  = din;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'd4);
        chk({tag, " data"}, out_state, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs [5];
        logic [127:0] held;
        int n;

        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;

        vecs[0] = '{din: {16{8'h63}}, dout: 128'h0};
        vecs[1] = '{din: {16{8'h16}}, dout: {16{8'hff}}};
        vecs[2] = '{din: 128'h76abd7fe2b670130c56f6bf27b777c63,
                    dout: 128'h0f0e0d0c0b0a09080706050403020100};
        vecs[3] = '{din: 128'h0, dout: {16{8'h52}}};
        vecs[4] = '{din: {16{8'hff}}, dout: {16{8'h7d}}};

        // Reset defaults
        repeat (3) tick();
        chk("rst in_ready", 128'(in_ready), 128'd1);
        chk("rst out_valid", 128'(out_valid), 128'd0);
        chk("rst out_state", out_state, 128'h0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle in_ready", 128'(in_ready), 128'd1);
        chk("idle out_valid", 128'(out_valid), 128'd0);

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));
        end

        // Backpressure then back-to-back handover
        in_state  = vecs[2].din;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp out_valid", 128'(out_valid), 128'd1);
        held = out_state;
        chk("bp first data", held, vecs[2].dout);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_state = {4{$urandom()}};
            tick();
            chk($sformatf("bp hold data %0d", i), out_state, held);
            chk($sformatf("bp in_ready %0d", i), 128'(in_ready), 128'd0);
            chk($sformatf("bp out_valid %0d", i), 128'(out_valid), 128'd1);
        end
        in_state  = vecs[1].din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b busy out_valid", 128'(out_valid), 128'd0);
        chk("b2b busy in_ready", 128'(in_ready), 128'd0);
        repeat (3) tick();
        chk("b2b early out_valid", 128'(out_valid), 128'd0);
        tick();
        chk("b2b out_valid", 128'(out_valid), 128'd1);
        chk("b2b data", out_state, vecs[1].dout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b back idle", 128'(in_ready), 128'd1);

        // Asynchronous reset two cycles into BUSY
        in_state = {16{8'h16}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst in_ready", 128'(in_ready), 128'd1);
        chk("arst out_valid", 128'(out_valid), 128'd0);
        chk("arst out_state", out_state, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        run_block(vecs[2].din, vecs[2].dout, "post-rst");

        // Round trip over every byte value in every byte position
        for (int x = 0; x < 256; x++) begin
            logic [127:0] din;
            logic [127:0] exp;
            for (int j = 0; j < 16; j++) begin
                logic [7:0] r;
                r = (j == x % 16) ? 8'(x) : 8'($urandom_range(0, 255));
                din[8*j +: 8] = SBOX[r];
                exp[8*j +: 8] = r;
            end
            run_block(din, exp, $sformatf("rt x=%0d", x));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
